// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, redirect and variable-latency data-RAM freezes.
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_wR,
  input  logic        ex_rf_we,
  input  logic        ex_is_load,
  input  logic        ex_redirect,
  input  logic        mem_access,
  input  logic        ram_ack,
  output logic        ram_req,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_stall,
  output logic        memwb_flush,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_lu_stall,
  output logic [31:0] perf_flush,
`endif
  output logic        mem_err
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);
  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, r_rst_d;
  logic             w_act, w_freeze, w_lu, w_rd, w_tmo;
  assign w_act = !rst && !r_rst_d;
  always_ff @(posedge clk) begin
    r_rst_d <= rst;
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (w_act) begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_tmo) r_err <= 1'b1;
    end
  end
  always_comb begin
    w_tmo     = r_state == MEM_WAIT && !ram_ack && (r_cnt + 1'b1) == TMO;
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    if (r_state == RUN) begin
      w_nxt     = (mem_access && !ram_ack) ? MEM_WAIT : RUN;
      w_cnt_nxt = (mem_access && !ram_ack) ? CNT_W'(1) : '0;
    end else begin
      w_nxt     = (ram_ack || w_tmo) ? RUN : MEM_WAIT;
      w_cnt_nxt = (ram_ack || w_tmo) ? '0 : r_cnt + 1'b1;
    end
  end
  // Freeze dominates; redirect squashes the ID instruction so it must not also stall.
  always_comb begin
    w_freeze    = w_act && (r_state == MEM_WAIT || (mem_access && !ram_ack));
    w_rd        = w_act && !w_freeze && ex_redirect;
    w_lu        = w_act && !w_freeze && ex_is_load && ex_rf_we && ex_wR != 5'd0 &&
                  ((id_rs1_used && id_rs1 == ex_wR) || (id_rs2_used && id_rs2 == ex_wR));
    ram_req     = w_act && (r_state == MEM_WAIT || mem_access);
    pc_stall    = w_freeze || (w_lu && !w_rd);
    ifid_stall  = w_freeze || (w_lu && !w_rd);
    ifid_flush  = w_rd;
    idex_stall  = w_freeze;
    idex_flush  = w_rd || w_lu;
    exmem_stall = w_freeze;
    memwb_flush = w_freeze;
    mem_err     = r_err;
  end
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_pm, r_pl, r_pf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pm <= '0;
      r_pl <= '0;
      r_pf <= '0;
    end else begin
      if (w_freeze && r_pm != '1) r_pm <= r_pm + 1'b1;
      if (w_lu && !w_rd && r_pl != '1) r_pl <= r_pl + 1'b1;
      if (w_rd && r_pf != '1) r_pf <= r_pf + 1'b1;
    end
  end
  assign perf_mem_stall = r_pm;
  assign perf_lu_stall  = r_pl;
  assign perf_flush     = r_pf;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed-vector self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_wR = '0;
  logic id_rs1_used = 0, id_rs2_used = 0, ex_rf_we = 0, ex_is_load = 0;
  logic ex_redirect = 0, mem_access = 0, ram_ack = 0;
  logic ram_req, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic exmem_stall, memwb_flush, mem_err;
  int n_run = 0, n_fail = 0;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_mem_stall, perf_lu_stall, perf_flush;
`endif
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_wR(ex_wR),
    .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .ram_ack(ram_ack), .ram_req(ram_req),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
    .memwb_flush(memwb_flush),
`ifdef HAZ_PERF_CNT_EN
    .perf_mem_stall(perf_mem_stall), .perf_lu_stall(perf_lu_stall), .perf_flush(perf_flush),
`endif
    .mem_err(mem_err));
  always #5 clk = ~clk;
  wire [7:0] w_outs = {ram_req, pc_stall, ifid_stall, ifid_flush,
                       idex_stall, idex_flush, exmem_stall, memwb_flush};
  localparam logic [7:0] FRZ = 8'hEB, LU = 8'h64, RD = 8'h14, ZW = 8'h80, NONE = 8'h00;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [7:0] exp);
    #2 check(tag, {24'd0, w_outs}, {24'd0, exp});
    @(posedge clk); #1;
  endtask
  task automatic set_lu(input logic [4:0] wr);
    ex_is_load = 1; ex_rf_we = 1; ex_wR = wr; id_rs2_used = 1; id_rs2 = 5;
  endtask
  task automatic clr;
    ex_is_load = 0; ex_rf_we = 0; ex_wR = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rs1 = 0; id_rs2 = 0; ex_redirect = 0; mem_access = 0; ram_ack = 0;
  endtask
  initial begin
    @(posedge clk); #1;
    mem_access = 1; ex_redirect = 1;
    cyc("reset_outs", NONE);
    check("reset_err", {31'd0, mem_err}, 0);
    rst = 0;
    cyc("post_reset_outs", NONE);
    mem_access = 0; ex_redirect = 0;
    cyc("post_reset_idle", NONE);
    set_lu(5);                                  cyc("lu_rs2", LU);
    set_lu(0);                                  cyc("lu_x0", NONE);
    clr; ex_is_load = 1; ex_rf_we = 1; ex_wR = 7; id_rs1 = 7; id_rs1_used = 1;
                                                cyc("lu_rs1", LU);
    id_rs1_used = 0;                            cyc("lu_rs1_unused", NONE);
    id_rs1_used = 1; ex_is_load = 0;            cyc("lu_not_load", NONE);
    clr; set_lu(5); ex_redirect = 1;            cyc("lu_plus_redirect", RD);
    clr; ex_redirect = 1;                       cyc("redirect", RD);
    mem_access = 1;
    for (int i = 0; i < 3; i++)                 cyc("wait3_frozen", FRZ);
    ram_ack = 1;                                cyc("wait3_ack", FRZ);
    mem_access = 0; ram_ack = 0;                cyc("wait3_redirect_after", RD);
    clr;                                        cyc("wait3_run", NONE);
    mem_access = 1; ram_ack = 1;                cyc("zero_wait", ZW);
    clr;                                        cyc("zero_wait_run", NONE);
    mem_access = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check("tmo_err_low", {31'd0, mem_err}, 0);
      cyc("tmo_frozen", FRZ);
    end
    mem_access = 0;
    check("tmo_err_set", {31'd0, mem_err}, 1);
    cyc("tmo_run", NONE);
    cyc("tmo_run2", NONE);
    check("tmo_err_sticky", {31'd0, mem_err}, 1);
`ifdef HAZ_PERF_CNT_EN
    check("perf_mem", perf_mem_stall, 8);
    check("perf_lu", perf_lu_stall, 2);
    check("perf_flush", perf_flush, 3);
`endif
    mem_access = 1;
    cyc("midwait_a", FRZ);
    cyc("midwait_b", FRZ);
    rst = 1;                                    cyc("midwait_rst", NONE);
    check("rst_err_clear", {31'd0, mem_err}, 0);
    rst = 0; ram_ack = 1;                       cyc("after_rst", NONE);
    cyc("after_rst_zero_wait", ZW);
    clr;                                        cyc("after_rst_idle", NONE);
    check("err_stays_clear", {31'd0, mem_err}, 0);
`ifdef HAZ_PERF_CNT_EN
    check("perf_mem_rst", perf_mem_stall, 0);
    check("perf_lu_rst", perf_lu_stall, 0);
    check("perf_flush_rst", perf_flush, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
